// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start, advance, branch, stall and halt.
// Optional retirement counter is compiled in when FETCH_RETIRE_CNT_EN is defined.
module fetch_sequencer #(
    parameter int D = 12,
    parameter int W = 9,
    parameter logic [W-1:0] HALT_CODE = 9'b111_111_111
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [D-1:0] start_addr,
    input  logic         stall,
    input  logic         branch_en,
    input  logic         branch_abs,
    input  logic [D-1:0] target,
    input  logic [W-1:0] mach_code,
    output logic [D-1:0] prog_ctr,
    output logic [W-1:0] instr,
    output logic         instr_valid,
    output logic         done,
    output logic [15:0]  retire_cnt,
    output logic [1:0]   state_dbg
);

    // One bit per active state so instr_valid and done come straight off flops.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [D-1:0] pc_next;
    logic [1:0]   state_bits;
    logic         is_halt;

    assign is_halt    = (mach_code == HALT_CODE);
    assign state_bits = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            prog_ctr <= '0;
        end else begin
            state    <= state_next;
            prog_ctr <= pc_next;
        end
    end

    // Stall beats halt, halt beats branch, branch beats sequential advance.
    always_comb begin
        state_next = state;
        pc_next    = prog_ctr;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_next = RUN;
                    pc_next    = start_addr;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_next = HALTED;
                    end else if (branch_en) begin
                        pc_next = branch_abs ? target : (prog_ctr + target);
                    end else begin
                        pc_next = prog_ctr + D'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign instr       = mach_code;
    assign instr_valid = state_bits[0];
    assign done        = state_bits[1];
    assign state_dbg   = state_bits;

`ifdef FETCH_RETIRE_CNT_EN
    logic [15:0] cnt;
    logic        retire;
    logic        start_ok;

    assign retire   = (state == RUN) && !stall && !is_halt;
    assign start_ok = start && (state != RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (start_ok) begin
            cnt <= '0;
        end else if (retire && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign retire_cnt = cnt;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [8:0] HALT = 9'h1FF;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] start_addr;
    logic        stall;
    logic        branch_en;
    logic        branch_abs;
    logic [11:0] target;
    logic [8:0]  mach_code;
    logic [11:0] prog_ctr;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        done;
    logic [15:0] retire_cnt;
    logic [1:0]  state_dbg;

    logic [8:0]  rom [0:4095];

    int checks = 0;
    int passes = 0;
    int m_mode;
    int m_pc;
    int m_ret;

    always #5 clk = ~clk;

    assign mach_code = rom[prog_ctr];

    fetch_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_abs (branch_abs),
        .target     (target),
        .mach_code  (mach_code),
        .prog_ctr   (prog_ctr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .done       (done),
        .retire_cnt (retire_cnt),
        .state_dbg  (state_dbg)
    );

    function automatic int exp_ret();
`ifdef FETCH_RETIRE_CNT_EN
        return m_ret;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_pc"}, 32'(prog_ctr), 32'(m_pc));
        chk({tag, "_valid"}, 32'(instr_valid), 32'(m_mode == M_RUN));
        chk({tag, "_done"}, 32'(done), 32'(m_mode == M_HALT));
        chk({tag, "_retire"}, 32'(retire_cnt), 32'(exp_ret()));
        if (m_mode == M_RUN) chk({tag, "_instr"}, 32'(instr), 32'(rom[m_pc]));
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, check after the edge.
    task automatic cycle(input string tag, input logic s, input logic [11:0] sa,
                         input logic st, input logic be, input logic ba, input logic [11:0] tg);
        logic [8:0] code;
        start = s; start_addr = sa; stall = st;
        branch_en = be; branch_abs = ba; target = tg;
        code = rom[m_pc];
        if (m_mode == M_RUN) begin
            if (!st) begin
                if (code == HALT) begin
                    m_mode = M_HALT;
                end else begin
                    if (be) m_pc = ba ? int'(tg) : (m_pc + int'(tg)) % 4096;
                    else    m_pc = (m_pc + 1) % 4096;
                    if (m_ret < 65535) m_ret++;
                end
            end
        end else if (s) begin
            m_mode = M_RUN;
            m_pc   = int'(sa);
            m_ret  = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between edges must take effect without waiting for a clock.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        m_mode = M_IDLE; m_pc = 0; m_ret = 0;
        #1 check_outputs(tag);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 9'h000;
        rom[12'h012] = HALT;
        rom[12'h005] = HALT;
        reset_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
        branch_en = 1'b0; branch_abs = 1'b0; target = '0;
        m_mode = M_IDLE; m_pc = 0; m_ret = 0;
        #3 check_outputs("reset");
        #9 reset_n = 1'b1;

        cycle("idle_hold", 0, 12'h000, 0, 0, 0, 12'h000);

        // Straight-line program ending in halt.
        cycle("t1_start", 1, 12'h010, 0, 0, 0, 12'h000);
        chk("t1_pc010", 32'(prog_ctr), 32'h010);
        cycle("t1_nop0", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t1_pc011", 32'(prog_ctr), 32'h011);
        cycle("t1_nop1", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t1_pc012", 32'(prog_ctr), 32'h012);
        cycle("t1_halt", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_pc_hold", 32'(prog_ctr), 32'h012);
`ifdef FETCH_RETIRE_CNT_EN
        chk("t1_retire2", 32'(retire_cnt), 32'h2);
`else
        chk("t1_retire0", 32'(retire_cnt), 32'h0);
`endif

        // Relative and absolute branches.
        cycle("t2_start", 1, 12'h020, 0, 0, 0, 12'h000);
        cycle("t2_rel", 0, 12'h000, 0, 1, 0, 12'hFFE);
        chk("t2_pc01e", 32'(prog_ctr), 32'h01E);
        cycle("t2_abs", 0, 12'h000, 0, 1, 1, 12'h100);
        chk("t2_pc100", 32'(prog_ctr), 32'h100);

        // Start while running is ignored.
        cycle("t6_run_start", 1, 12'h300, 0, 0, 0, 12'h000);
        chk("t6_pc101", 32'(prog_ctr), 32'h101);

        // Wrap-around in both directions.
        cycle("t4_to_fff", 0, 12'h000, 0, 1, 1, 12'hFFF);
        cycle("t4_wrap", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t4_pc000", 32'(prog_ctr), 32'h000);
        chk("t4_still_run", 32'(instr_valid), 32'h1);
        cycle("t4_rel_m1", 0, 12'h000, 0, 1, 0, 12'hFFF);
        chk("t4_pcfff", 32'(prog_ctr), 32'hFFF);

        // Stall over a halt instruction, with a branch request that must be ignored.
        cycle("t3_to_005", 0, 12'h000, 0, 1, 1, 12'h005);
        for (int i = 0; i < 3; i++) begin
            cycle("t3_stall", 0, 12'h000, 1, 1, 1, 12'h300);
            chk("t3_stall_done", 32'(done), 32'h0);
            chk("t3_stall_pc", 32'(prog_ctr), 32'h005);
        end
        cycle("t3_release", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t3_done", 32'(done), 32'h1);

        // Restart from halted clears the retirement count.
        cycle("t6_restart", 1, 12'h040, 0, 0, 0, 12'h000);
        chk("t6_done0", 32'(done), 32'h0);
        chk("t6_pc040", 32'(prog_ctr), 32'h040);
        chk("t6_retire0", 32'(retire_cnt), 32'h0);

        // Asynchronous reset mid-run, then start is needed to resume.
        cycle("t5_to_0a3", 0, 12'h000, 0, 1, 1, 12'h0A3);
        async_reset("t5_reset");
        chk("t5_pc0", 32'(prog_ctr), 32'h000);
        cycle("t5_idle", 0, 12'h000, 0, 0, 0, 12'h000);
        chk("t5_idle_valid", 32'(instr_valid), 32'h0);
        cycle("t5_resume", 1, 12'h0A3, 0, 0, 0, 12'h000);

        // Random program image and control traffic.
        for (int i = 0; i < 4096; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? HALT : 9'($urandom_range(0, 510));
        for (int n = 0; n < 600; n++) begin
            cycle("rnd",
                  1'($urandom_range(0, 2) == 0), 12'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 12'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset("rnd_reset");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer for the 9-bit instruction ROM. It owns the 12-bit `prog_ctr` address that drives the ROM and receives the combinational `mach_code` back. Each cycle it advances, branches or holds the PC, and it stops on a halt opcode. It sits between the ROM and the decode/execute datapath, which supplies the branch and stall controls.

## Interface
Parameters:
- `D`, 12, PC / ROM address width
- `W`, 9, instruction width
- `HALT_CODE`, 9'b111_111_111, opcode that terminates execution

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin execution at `start_addr` (IDLE or HALTED only)
- `start_addr`  in  D  first instruction address
- `stall`  in  1  hold PC this cycle
- `branch_en`  in  1  take a branch this cycle
- `branch_abs`  in  1  1 = absolute target, 0 = PC-relative
- `target`  in  D  absolute address, or two's-complement offset
- `mach_code`  in  W  instruction returned by the ROM for `prog_ctr`
- `prog_ctr`  out  D  ROM address (registered)
- `instr`  out  W  equals `mach_code`; meaningful only when `instr_valid`=1
- `instr_valid`  out  1  1 in RUN state
- `done`  out  1  1 in HALTED state
- `retire_cnt`  out  16  count of retired instructions (see Configuration)

## Operation
- FSM states: IDLE, RUN, HALTED.
- Reset (async, `reset_n`=0): state=IDLE, `prog_ctr`=0, `instr_valid`=0, `done`=0, `retire_cnt`=0.
- IDLE: `start`=1 -> RUN, `prog_ctr`<=`start_addr`. Otherwise hold.
- RUN, one decision per cycle in this priority order:
  1. `stall`=1: hold PC and state. Branch and halt are ignored.
  2. `mach_code`==`HALT_CODE`: go to HALTED. PC holds on the halt address.
  3. `branch_en`=1: `prog_ctr`<=`target` if `branch_abs`=1, else `prog_ctr`+`target` mod 2^D (offset sign-extended within D bits).
  4. Else: `prog_ctr`<=`prog_ctr`+1 mod 2^D.
- Retirement is any RUN cycle with `stall`=0 that does not take the halt path.
- `start` in RUN is ignored.
- HALTED: `done`=1 and PC holds. `start`=1 -> RUN, `prog_ctr`<=`start_addr`, `done`<=0.
- Wrap-around: PC 0xFFF increments to 0x000 with no flag. A relative branch of -1 from 0x000 yields 0xFFF.
- `reset_n` asserted mid-RUN or mid-stall returns to IDLE immediately; the in-progress instruction is not retired.

## Timing
- All state, `prog_ctr` and counters update on the rising `clk` edge. Reset is the only asynchronous path.
- `instr_valid` and `done` are decoded from state register bits (glitch-free).
- `instr` is combinational from `mach_code` through the ROM, giving zero-cycle fetch latency.
- `start` sampled at edge n: `prog_ctr`=`start_addr` and `instr_valid`=1 from n+1.
- Halt opcode presented unstalled at edge n: `done`=1 and `instr_valid`=0 from n+1.
- Branch sampled at edge n: new PC is visible from n+1. There is no delay slot.
- The datapath must drive `branch_en`, `target` and `stall` combinationally from the current `instr` within the same cycle.

## Configuration
- Macro `FETCH_RETIRE_CNT_EN`.
- Defined:
  - `retire_cnt` increments by 1 on each retirement.
  - It saturates at 0xFFFF.
  - It clears to 0 when `start` is accepted, and holds in IDLE and HALTED.
- Undefined: the counter logic is compiled out and `retire_cnt` is tied to 16'h0000.

## Test plan
- Reset, then `start` with `start_addr`=0x010 over ROM [0x010]=NOP, [0x011]=NOP, [0x012]=HALT -> `prog_ctr` 0x010, 0x011, 0x012. `done`=1 on the fourth cycle; `retire_cnt`=2 (macro on).
- `branch_en`=1, `branch_abs`=0, `target`=0xFFE at PC 0x020 -> next PC 0x01E. `branch_abs`=1, `target`=0x100 -> next PC 0x100.
- `stall` high for 3 cycles at PC 0x005 while the instruction is HALT -> PC stays 0x005 with `done`=0. Release `stall` -> `done`=1 next cycle.
- PC 0xFFF with a non-halt, non-branch instruction -> next PC 0x000 and the FSM stays in RUN.
- `reset_n` pulled low between clock edges in RUN at PC 0x0A3 -> `prog_ctr`=0 and `instr_valid`=0 immediately. After reset is released, `start` is required to resume.
- In HALTED, pulse `start` with `start_addr`=0x040 -> `done`=0, PC=0x040 next cycle, `retire_cnt` cleared. `start` pulsed during RUN has no effect.
